// File: rtl/sched_seq_ctrl_if.sv
// Handshake, configuration and datapath-control bundle of the table-driven sequencer.
// The master side issues run and configuration requests. The slave side is the sequencer.
interface sched_seq_ctrl_if #(
    parameter int N_FU    = 4,
    parameter int SEL_W   = 4,
    parameter int OP_W    = 2,
    parameter int N_REGS  = 16,
    parameter int N_STEPS = 16,
    parameter int WAIT_W  = 2,
    parameter int ITER_W  = 8
) ();
    localparam int IDX_W = $clog2(N_STEPS);
    localparam int CW_W  = N_FU * (2 * SEL_W + OP_W) + N_REGS + WAIT_W + 2;

    logic                   start;
    logic [ITER_W-1:0]      iters;
    logic                   hold;
    logic                   abort;
    logic                   cfg_we;
    logic [IDX_W-1:0]       cfg_addr;
    logic [CW_W-1:0]        cfg_data;
    logic                   op_ready;
    logic                   done_next;
    logic                   result_en;
    logic [N_FU*SEL_W-1:0]  fu_sel1;
    logic [N_FU*SEL_W-1:0]  fu_sel2;
    logic [N_FU*OP_W-1:0]   fu_op;
    logic [N_REGS-1:0]      reg_en;
    logic [IDX_W-1:0]       step_idx;

    modport master (
        output start, iters, hold, abort, cfg_we, cfg_addr, cfg_data,
        input  op_ready, done_next, result_en, fu_sel1, fu_sel2, fu_op, reg_en, step_idx
    );

    modport slave (
        input  start, iters, hold, abort, cfg_we, cfg_addr, cfg_data,
        output op_ready, done_next, result_en, fu_sel1, fu_sel2, fu_op, reg_en, step_idx
    );
endinterface

// File: rtl/sched_seq_ctrl.sv
// Table-driven datapath sequencer. It steps through a programmable control-word table, and each step can last several cycles.
// It supports stall, abort and N-fold repetition of the schedule. The outputs decode directly from the state and the table.
module sched_seq_ctrl #(
    parameter int N_FU    = 4,
    parameter int SEL_W   = 4,
    parameter int OP_W    = 2,
    parameter int N_REGS  = 16,
    parameter int N_STEPS = 16,
    parameter int WAIT_W  = 2,
    parameter int ITER_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    sched_seq_ctrl_if.slave  bus
);
    localparam int IDX_W    = $clog2(N_STEPS);
    localparam int CW_W     = N_FU * (2 * SEL_W + OP_W) + N_REGS + WAIT_W + 2;
    localparam int SEL1_LSB = 0;
    localparam int SEL2_LSB = N_FU * SEL_W;
    localparam int OP_LSB   = 2 * N_FU * SEL_W;
    localparam int REG_LSB  = OP_LSB + N_FU * OP_W;
    localparam int RES_BIT  = REG_LSB + N_REGS;
    localparam int WAIT_LSB = RES_BIT + 1;
    localparam int LAST_BIT = WAIT_LSB + WAIT_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [IDX_W-1:0]  STEP_LAST = IDX_W'(N_STEPS - 1);

    logic [CW_W-1:0]   table_r [N_STEPS];
    logic [1:0]        state_r;
    logic [IDX_W-1:0]  step_r;
    logic [ITER_W-1:0] iter_left_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    logic [IDX_W-1:0]  step_nx_s;
    logic [WAIT_W-1:0] start_wait_s;
    logic [WAIT_W-1:0] next_wait_s;
    logic [WAIT_W-1:0] wrap_wait_s;
    logic              commit_s;
    logic              end_pass_s;

    // Control-word table: configurable only while idle, never cleared by reset
    always_ff @(posedge clk) begin
        if (state_r == ST_IDLE && bus.cfg_we) begin
            table_r[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Step bookkeeping: commit qualification, pass end, and the wait field of the following word
    always_comb begin
        step_nx_s   = step_r + 1'b1;
        next_wait_s = table_r[step_nx_s][WAIT_LSB +: WAIT_W];
        wrap_wait_s = table_r[0][WAIT_LSB +: WAIT_W];
        commit_s    = (state_r == ST_RUN) && (wait_cnt_r == {WAIT_W{1'b0}})
                      && !bus.hold && !bus.abort;
        end_pass_s  = table_r[step_r][LAST_BIT] || (step_r == STEP_LAST);
        // A same-cycle write to word 0 must be seen by the run it starts
        if (bus.cfg_we && bus.cfg_addr == {IDX_W{1'b0}}) begin
            start_wait_s = bus.cfg_data[WAIT_LSB +: WAIT_W];
        end else begin
            start_wait_s = table_r[0][WAIT_LSB +: WAIT_W];
        end
    end

    // Sequencer state: IDLE -> RUN (steps, waits, passes) -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            step_r      <= {IDX_W{1'b0}};
            iter_left_r <= {ITER_W{1'b0}};
            wait_cnt_r  <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r     <= ST_RUN;
                        step_r      <= {IDX_W{1'b0}};
                        iter_left_r <= (bus.iters == {ITER_W{1'b0}}) ? ITER_ONE : bus.iters;
                        wait_cnt_r  <= start_wait_s;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_r     <= ST_IDLE;
                        step_r      <= {IDX_W{1'b0}};
                        iter_left_r <= {ITER_W{1'b0}};
                        wait_cnt_r  <= {WAIT_W{1'b0}};
                    end else if (bus.hold) begin
                        state_r <= ST_RUN;
                    end else if (wait_cnt_r != {WAIT_W{1'b0}}) begin
                        wait_cnt_r <= wait_cnt_r - 1'b1;
                    end else if (end_pass_s) begin
                        step_r <= {IDX_W{1'b0}};
                        if (iter_left_r == ITER_ONE) begin
                            state_r     <= ST_DONE;
                            iter_left_r <= {ITER_W{1'b0}};
                            wait_cnt_r  <= {WAIT_W{1'b0}};
                        end else begin
                            iter_left_r <= iter_left_r - 1'b1;
                            wait_cnt_r  <= wrap_wait_s;
                        end
                    end else begin
                        step_r     <= step_nx_s;
                        wait_cnt_r <= next_wait_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    step_r      <= {IDX_W{1'b0}};
                    iter_left_r <= {ITER_W{1'b0}};
                    wait_cnt_r  <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode: mux and opcode fields follow the current word, enables fire only on commit
    always_comb begin
        bus.op_ready  = 1'b0;
        bus.done_next = 1'b0;
        bus.result_en = 1'b0;
        bus.fu_sel1   = {(N_FU*SEL_W){1'b0}};
        bus.fu_sel2   = {(N_FU*SEL_W){1'b0}};
        bus.fu_op     = {(N_FU*OP_W){1'b0}};
        bus.reg_en    = {N_REGS{1'b0}};
        bus.step_idx  = step_r;
        case (state_r)
            ST_IDLE: begin
                bus.op_ready = 1'b1;
            end
            ST_RUN: begin
                bus.fu_sel1 = table_r[step_r][SEL1_LSB +: N_FU*SEL_W];
                bus.fu_sel2 = table_r[step_r][SEL2_LSB +: N_FU*SEL_W];
                bus.fu_op   = table_r[step_r][OP_LSB +: N_FU*OP_W];
                if (commit_s) begin
                    bus.reg_en    = table_r[step_r][REG_LSB +: N_REGS];
                    bus.result_en = table_r[step_r][RES_BIT];
                end else begin
                    bus.reg_en    = {N_REGS{1'b0}};
                    bus.result_en = 1'b0;
                end
            end
            ST_DONE: begin
                bus.done_next = !bus.abort;
            end
            default: begin
                bus.op_ready = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_sched_seq_ctrl.sv
// Self-checking bench for sched_seq_ctrl. A shadow table and a run generator push the expected output vectors to a scoreboard.
// Each cycle pops one vector and compares it with the outputs.
module tb_sched_seq_ctrl;
    localparam int CW_W = 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sched_seq_ctrl_if bus ();

    sched_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              err_cnt = 0;
    int              chk_cnt = 0;
    logic [62:0]     exp_q[$];
    logic [CW_W-1:0] tb_tab [16];

    task automatic check_val(input string tag, input logic [62:0] obs, input logic [62:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [62:0] exp_idle();
        return {1'b1, 62'd0};
    endfunction

    function automatic logic [62:0] exp_done();
        return {1'b0, 1'b1, 61'd0};
    endfunction

    function automatic logic [62:0] exp_run(input logic [CW_W-1:0] w, input logic [3:0] s, input bit commit);
        return {1'b0, 1'b0, (commit ? w[56] : 1'b0), (commit ? w[55:40] : 16'd0),
                s, w[39:32], w[31:16], w[15:0]};
    endfunction

    function automatic logic [CW_W-1:0] mk_word(input bit res, input logic [1:0] wt, input bit last);
        logic [CW_W-1:0] w;
        w[31:0]  = $urandom;
        w[39:32] = 8'($urandom);
        w[55:40] = 16'($urandom) | 16'h0001;
        w[56]    = res;
        w[58:57] = wt;
        w[59]    = last;
        return w;
    endfunction

    // One clock cycle: drive inputs, queue the expected vector, then sample and compare
    task automatic cyc(input bit st, input bit hd, input bit ab, input bit rs, input bit we,
                       input logic [3:0] addr, input logic [CW_W-1:0] data, input logic [7:0] it,
                       input logic [62:0] e, input string tag);
        logic [62:0] obs;
        @(negedge clk);
        rst          = rs;
        bus.start    = st;
        bus.hold     = hd;
        bus.abort    = ab;
        bus.cfg_we   = we;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        bus.iters    = it;
        exp_q.push_back(e);
        #2;
        obs = {bus.op_ready, bus.done_next, bus.result_en, bus.reg_en, bus.step_idx,
               bus.fu_op, bus.fu_sel2, bus.fu_sel1};
        check_val(tag, obs, exp_q.pop_front());
    endtask

    task automatic wr(input int a, input logic [CW_W-1:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(a), d, 8'd0, exp_idle(), "cfg_idle");
        tb_tab[a] = d;
    endtask

    task automatic run_cyc(input logic [CW_W-1:0] w, input logic [3:0] s, input bit commit,
                           input bit hd, input bit ab, input bit rs, input bit noise,
                           input int rc, input string tag);
        cyc(1'b0, hd, ab, rs, noise, 4'(rc), {CW_W{1'b1}}, 8'd0, exp_run(w, s, commit), tag);
    endtask

    // Expected run: passes x steps x (wait+1) cycles, with optional hold window and abort/reset point
    task automatic do_run(input logic [7:0] it, input int hold_at, input int hold_len,
                          input int stop_at, input bit stop_rst, input bit noise);
        int              rc;
        int              np;
        int              wt;
        bit              stopped;
        bit              end_pass;
        bit              held;
        logic [CW_W-1:0] w;
        logic [3:0]      s;
        np      = (it == 8'd0) ? 1 : int'(it);
        rc      = 0;
        stopped = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, {CW_W{1'b0}}, it, exp_idle(), "start");
        for (int p = 0; p < np && !stopped; p++) begin
            s        = 4'd0;
            end_pass = 1'b0;
            while (!end_pass && !stopped) begin
                w  = tb_tab[s];
                wt = int'(w[58:57]);
                for (int k = 0; k <= wt && !stopped; k++) begin
                    held = 1'b1;
                    while (held && !stopped) begin
                        held = (rc >= hold_at) && (rc < hold_at + hold_len);
                        if (rc == stop_at) begin
                            run_cyc(w, s, 1'b0, stop_rst, !stop_rst, stop_rst, noise, rc, "stop");
                            stopped = 1'b1;
                        end else begin
                            run_cyc(w, s, !held && (k == wt), held, 1'b0, 1'b0, noise, rc,
                                    held ? "hold" : "run");
                        end
                        rc++;
                    end
                end
                end_pass = w[59] || (s == 4'd15);
                s++;
            end
        end
        if (!stopped) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, {CW_W{1'b0}}, 8'd0, exp_done(), "done");
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, {CW_W{1'b0}}, 8'd0, exp_idle(), "back_idle");
    endtask

    initial begin
        logic [CW_W-1:0] w;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.hold     = 1'b0;
        bus.abort    = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = 4'd0;
        bus.cfg_data = {CW_W{1'b0}};
        bus.iters    = 8'd0;
        repeat (3) @(posedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, {CW_W{1'b0}}, 8'd0, exp_idle(), "in_reset");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, {CW_W{1'b0}}, 8'd0, exp_idle(), "reset_state");

        // Four single-cycle steps, last and result on step 3
        for (int i = 0; i < 4; i++) wr(i, mk_word(i == 3, 2'd0, i == 3));
        do_run(8'd1, -1, 0, -1, 1'b0, 1'b0);

        // Step 1 spans three cycles
        w = tb_tab[1];
        w[58:57] = 2'd2;
        wr(1, w);
        do_run(8'd1, -1, 0, -1, 1'b0, 1'b0);

        // Hold two cycles over the step-0 commit
        do_run(8'd1, 0, 2, -1, 1'b0, 1'b0);

        // Step 2 waits one cycle; abort in its first cycle while cfg writes are attempted
        w = tb_tab[2];
        w[58:57] = 2'd1;
        wr(2, w);
        do_run(8'd1, -1, 0, 4, 1'b0, 1'b1);
        do_run(8'd1, -1, 0, -1, 1'b0, 1'b0);

        // Two-step table repeated, then iters=0
        wr(0, mk_word(1'b0, 2'd0, 1'b0));
        wr(1, mk_word(1'b1, 2'd0, 1'b1));
        do_run(8'd3, -1, 0, -1, 1'b0, 1'b0);
        do_run(8'd0, -1, 0, -1, 1'b0, 1'b0);

        // Full 16-entry table without a last bit
        for (int i = 0; i < 16; i++) wr(i, mk_word(i == 15, 2'(i % 2), 1'b0));
        do_run(8'd1, -1, 0, -1, 1'b0, 1'b0);
        do_run(8'd2, -1, 0, 9, 1'b1, 1'b0);
        do_run(8'd1, -1, 0, -1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
